// File: rtl/counter_priority_scheduler.sv
// Counter-increment scheduler: per-cell pending/direction flags, lowest-index
// grant at T12, single-service IDLE/SERVE handshake with ACK watchdog.
module counter_priority_scheduler (
  input  logic       CLOCK,
  input  logic       SIM_RST,
  input  logic       T12,
  input  logic       INHINC,
  input  logic [7:0] PREQ,
  input  logic [7:0] MREQ,
  input  logic       ACK,
  output logic       INKL,
  output logic       PINC,
  output logic       MINC,
  output logic [2:0] CADR,
  output logic [7:0] PEND,
  output logic       OVRN,
  output logic       TMOUT
);
  localparam int NUM_CELLS = 8;
  localparam logic [3:0] WDOG_LIMIT = 4'd15;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_CELLS-1:0]   pend_q, pend_d;
  logic [NUM_CELLS-1:0]   dir_q, dir_d;
  logic [2:0]             cadr_q, cadr_d;
  logic                   pinc_q, pinc_d;
  logic                   minc_q, minc_d;
  logic                   ovrn_q, ovrn_d;
  logic                   tmout_q, tmout_d;
  logic [3:0]             wdog_q, wdog_d;

  logic [2:0] grant_idx;
  logic       grant_found;
  logic       grant;
  logic [3:0] wdog_inc;
  logic       done_ack, done_to, done;

  // Lowest set index of the pre-request pending vector wins.
  always_comb begin
    grant_idx   = 3'd0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (!grant_found && pend_q[i]) begin
        grant_idx   = 3'(i);
        grant_found = 1'b1;
      end
    end
  end

  assign grant    = (state_q == IDLE) && T12 && !INHINC && (|pend_q);
  assign wdog_inc = wdog_q + 4'd1;
  assign done_ack = (state_q == SERVE) && ACK;
  assign done_to  = (state_q == SERVE) && !ACK && (wdog_inc == WDOG_LIMIT);
  assign done     = done_ack || done_to;

  // Service sequencing.
  always_comb begin
    state_d = state_q;
    cadr_d  = cadr_q;
    pinc_d  = pinc_q;
    minc_d  = minc_q;
    wdog_d  = wdog_q;
    tmout_d = tmout_q;
    case (state_q)
      IDLE: begin
        wdog_d = 4'd0;
        if (grant) begin
          state_d = SERVE;
          cadr_d  = grant_idx;
          pinc_d  = ~dir_q[grant_idx];
          minc_d  = dir_q[grant_idx];
        end
      end
      SERVE: begin
        wdog_d = wdog_inc;
        if (done) begin
          state_d = IDLE;
          pinc_d  = 1'b0;
          minc_d  = 1'b0;
          wdog_d  = 4'd0;
          if (done_to) tmout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-cell request merge. The completing service clears first so a request
  // landing on the same edge re-arms the cell. A cell held in service (or being
  // granted this edge) has no room to queue a second request, so it is dropped.
  always_comb begin
    pend_d = pend_q;
    dir_d  = dir_q;
    ovrn_d = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      logic base_pend;
      logic svc_hold;
      logic req;
      logic rdir;
      base_pend = pend_q[i] && !(done && (cadr_q == 3'(i)));
      svc_hold  = ((state_q == SERVE) && !done && (cadr_q == 3'(i))) ||
                  (grant && (grant_idx == 3'(i)));
      req       = PREQ[i] ^ MREQ[i];
      rdir      = MREQ[i];
      pend_d[i] = base_pend;
      if (req) begin
        if (svc_hold) begin
          ovrn_d = 1'b1;
        end else if (!base_pend) begin
          pend_d[i] = 1'b1;
          dir_d[i]  = rdir;
        end else if (dir_q[i] != rdir) begin
          pend_d[i] = 1'b0;
        end else begin
          ovrn_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state_q <= IDLE;
      pend_q  <= '0;
      dir_q   <= '0;
      cadr_q  <= 3'd0;
      pinc_q  <= 1'b0;
      minc_q  <= 1'b0;
      ovrn_q  <= 1'b0;
      tmout_q <= 1'b0;
      wdog_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      cadr_q  <= cadr_d;
      pinc_q  <= pinc_d;
      minc_q  <= minc_d;
      ovrn_q  <= ovrn_d;
      tmout_q <= tmout_d;
      wdog_q  <= wdog_d;
    end
  end

  assign INKL  = (state_q == SERVE);
  assign PINC  = pinc_q;
  assign MINC  = minc_q;
  assign CADR  = cadr_q;
  assign PEND  = pend_q;
  assign OVRN  = ovrn_q;
  assign TMOUT = tmout_q;

endmodule

// File: doc/counter_priority_scheduler.md
COUNTER_PRIORITY_SCHEDULER -- requirements
Module: counter_priority_scheduler

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: CLOCK (single clock) and SIM_RST (reset, asynchronous, active-high).
REQ-002 SHALL expose these ports, clock and reset first:
- CLOCK  in  1  system clock; all state updates on its rising edge
- SIM_RST  in  1  asynchronous active-high reset
- T12  in  1  one-clock pulse marking the end of a memory cycle (grant sampling point)
- INHINC  in  1  inhibit counter service; suppresses new grants only
- PREQ  in  8  plus-increment request pulses, one bit per counter cell
- MREQ  in  8  minus-increment request pulses, one bit per counter cell
- ACK  in  1  datapath reports increment complete (one-clock pulse)
- INKL  out  1  counter cycle in progress; inhibits SQ load
- PINC  out  1  plus-increment strobe to the crosspoint logic
- MINC  out  1  minus-increment strobe to the crosspoint logic
- CADR  out  3  index of the cell being serviced
- PEND  out  8  pending-request flags, one per cell
- OVRN  out  1  one-clock pulse: a request was lost
- TMOUT  out  1  sticky flag: ACK timeout occurred

Function
REQ-003 SHALL keep, per cell, a pending bit PEND[i] and a direction bit DIR[i] (1 = minus).
REQ-004 SHALL set PEND[i] with DIR[i]=0 when PREQ[i]=1 and MREQ[i]=0 arrive while PEND[i]=0.
REQ-005 SHALL set PEND[i] with DIR[i]=1 when MREQ[i]=1 and PREQ[i]=0 arrive while PEND[i]=0.
REQ-006 SHALL treat simultaneous PREQ[i] and MREQ[i] as a net-zero request: no state change and no OVRN.
REQ-007 SHALL, when a request arrives opposite to a pending, not-in-service DIR[i], clear PEND[i] (cancellation) without asserting OVRN.
REQ-008 SHALL, when a request arrives in the same direction as a pending PEND[i], drop it and pulse OVRN for one clock.
REQ-009 SHALL treat any request to the cell currently in service as a fresh request that is applied after the service completes in the same clock edge, so a new request wins over the clear caused by ACK.
REQ-010 SHALL implement the state machine IDLE -> SERVE -> IDLE.
REQ-011 SHALL leave IDLE for SERVE on the clock edge where T12=1, INHINC=0 and PEND!=0.
REQ-012 SHALL, on that IDLE-to-SERVE edge, select the lowest index i with PEND[i]=1 (cell 0 has highest priority), using PEND as it stood before that cycle's new requests.
REQ-013 SHALL latch CADR=i and drive PINC=~DIR[i] and MINC=DIR[i]; the selected cell and direction SHALL stay frozen for the whole of SERVE.
REQ-014 SHALL hold INKL=1 throughout SERVE and hold INKL=0 in IDLE.
REQ-015 SHALL, in SERVE, clear PEND[CADR] on ACK, drop PINC and MINC, and return to IDLE on the same edge.
REQ-016 SHALL make the first grant possible only at the next T12 after returning to IDLE; at most one grant per memory cycle.
REQ-017 SHALL keep a 4-bit watchdog that is zero on entry to SERVE and increments each SERVE clock without ACK.
REQ-018 SHALL, when the watchdog reaches 15, set TMOUT, clear PEND[CADR] and return to IDLE; TMOUT SHALL clear only on reset.
REQ-019 SHALL ignore ACK while in IDLE.
REQ-020 SHALL let INHINC or T12 changes during SERVE have no effect on the service in progress.

Reset
REQ-021 SHALL, on SIM_RST asserted at any time, immediately force state=IDLE, PEND=0, DIR=0, CADR=0, PINC=0, MINC=0, INKL=0, OVRN=0, TMOUT=0 and watchdog=0.
REQ-022 SHALL abandon any service in progress on reset without emitting an ACK-related clear.

Verification
REQ-023 Single request: PREQ[3] pulse, then T12 -> next clock INKL=1, CADR=3, PINC=1; ACK -> PEND=0x00, INKL=0.
REQ-024 Priority: PREQ[5] and MREQ[1] pending at T12 -> CADR=1, MINC=1; after ACK, next T12 -> CADR=5, PINC=1.
REQ-025 Cancel and overrun: PREQ[2] then MREQ[2] -> PEND[2]=0, OVRN=0; PREQ[4] twice -> OVRN pulses once, PEND[4]=1.
REQ-026 Inhibit and timeout: INHINC=1 at T12 with PEND=0x01 -> no grant; then grant with ACK withheld 15 clocks -> TMOUT=1, PEND[0]=0, INKL=0.
REQ-027 Reset mid-service: SIM_RST during SERVE with PEND=0x81 -> all outputs 0 asynchronously; no grant until a new request and T12.
